// File: rtl/dp_pkg.sv
// Shared definitions for the two-stage register/ALU datapath: opcodes, field positions, stage control.
// Pure declarations; no latency or flow-control behaviour of its own.
package dp_pkg;

   localparam int DP_DATA_W  = 16;
   localparam int DP_REG_CNT = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_SLL   = 4'h6,
      OP_SRL   = 4'h7,
      OP_SRA   = 4'h8,
      OP_ROL   = 4'h9,
      OP_MOV   = 4'hA,
      OP_ADDI  = 4'hB,
      OP_NOP_C = 4'hC,
      OP_NOP_D = 4'hD,
      OP_NOP_E = 4'hE,
      OP_NOP_F = 4'hF
   } opcode_e;

   // Control captured alongside the operands in stage 1.
   typedef struct packed {
      logic       load;
      opcode_e    op;
      logic [3:0] rd;
      logic [3:0] imm4;
   } s1_ctl_t;

   // Opcodes C-F retire without producing a result.
   function automatic logic op_writes(input opcode_e op);
      return (op <= OP_ADDI);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and carry from two operands, opcode and a 4-bit immediate.
// Zero latency; no flow control.
module alu_core
   import dp_pkg::*;
#(
   parameter int W = DP_DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  opcode_e      op,
   input  logic [3:0]   imm4,
   output logic [W-1:0] result,
   output logic         carry
);

   logic [W:0]     sum;
   logic [W:0]     diff;
   logic [W:0]     addi;
   logic [W-1:0]   immx;
   logic [2*W-1:0] rot;

   assign immx = {{(W-4){1'b0}}, imm4};
   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign addi = {1'b0, a} + {1'b0, immx};
   // Upper half of the doubled word shifted left is the left rotation.
   assign rot  = {a, a} << imm4;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin
            result = sum[W-1:0];
            carry  = sum[W];
         end
         OP_SUB: begin
            result = diff[W-1:0];
            carry  = ~diff[W];
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SLL:  result = a << imm4;
         OP_SRL:  result = a >> imm4;
         OP_SRA:  result = $signed(a) >>> imm4;
         OP_ROL:  result = rot[2*W-1:W];
         OP_MOV:  result = a;
         OP_ADDI: begin
            result = addi[W-1:0];
            carry  = addi[W];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage register-file datapath: operand capture with write-back bypass, then ALU/load retire.
// Result registered two edges after issue (capture edge + retire edge); accepts one per cycle, never stalls.
module pipe_datapath
   import dp_pkg::*;
#(
   parameter int DATA_W  = DP_DATA_W,
   parameter int REG_CNT = DP_REG_CNT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       Instruction,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] DataInit,
   input  logic              InitSel,
   output logic [DATA_W-1:0] ALUOut,
   output logic              out_valid,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic [15:0]       retired_cnt
);

   logic [DATA_W-1:0] regs [REG_CNT];

   logic              s1_vld;
   s1_ctl_t           s1_ctl;
   s1_ctl_t           s1_nxt;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;

   logic [3:0]        rs1;
   logic [3:0]        rs2;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;

   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              s2_produces;
   logic              s2_wen;
   logic [DATA_W-1:0] s2_res;

   assign rs1 = Instruction[RS1_MSB:RS1_LSB];
   assign rs2 = Instruction[RS2_MSB:RS2_LSB];

   always_comb begin
      s1_nxt      = '0;
      s1_nxt.load = InitSel;
      s1_nxt.op   = opcode_e'(Instruction[OP_MSB:OP_LSB]);
      s1_nxt.rd   = Instruction[RD_MSB:RD_LSB];
      s1_nxt.imm4 = Instruction[RS2_MSB:RS2_LSB];
   end

   alu_core #(.W(DATA_W)) u_alu (
      .a      (s1_a),
      .b      (s1_b),
      .op     (s1_ctl.op),
      .imm4   (s1_ctl.imm4),
      .result (alu_res),
      .carry  (alu_carry)
   );

   // Loads carry their value through the stage-1 A operand slot.
   assign s2_produces = s1_ctl.load || op_writes(s1_ctl.op);
   assign s2_res      = s1_ctl.load ? s1_a : alu_res;
   assign s2_wen      = s1_vld && s2_produces && (s1_ctl.rd != 4'd0);

   // The retiring instruction's result overrides the register it writes this same edge.
   always_comb begin
      opa = '0;
      opb = '0;
      if (rs1 != 4'd0) begin
         opa = (s2_wen && (s1_ctl.rd == rs1)) ? s2_res : regs[rs1];
      end
      if (rs2 != 4'd0) begin
         opb = (s2_wen && (s1_ctl.rd == rs2)) ? s2_res : regs[rs2];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < REG_CNT; i++) begin
            regs[i] <= '0;
         end
      end else if (s2_wen) begin
         regs[s1_ctl.rd] <= s2_res;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_vld <= 1'b0;
         s1_ctl <= '0;
         s1_a   <= '0;
         s1_b   <= '0;
      end else begin
         s1_vld <= instr_valid;
         if (instr_valid) begin
            s1_ctl <= s1_nxt;
            s1_a   <= InitSel ? DataInit : opa;
            s1_b   <= opb;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALUOut      <= '0;
         out_valid   <= 1'b0;
         zero_flag   <= 1'b0;
         carry_flag  <= 1'b0;
         retired_cnt <= '0;
      end else begin
         out_valid <= s1_vld;
         if (s1_vld) begin
            retired_cnt <= retired_cnt + 16'd1;
            if (s2_produces) begin
               ALUOut     <= s2_res;
               zero_flag  <= (s2_res == '0);
               carry_flag <= s1_ctl.load ? 1'b0 : alu_carry;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_datapath.sv
// Directed bench for pipe_datapath at DATA_W 16 and 32, both instances fed the same instruction stream.
module tb_pipe_datapath;
   import dp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        iv;
   logic        sel;
   logic [15:0] d16;
   logic [31:0] d32;

   logic [15:0] o16;
   logic        ov16, z16, c16;
   logic [15:0] n16;
   logic [31:0] o32;
   logic        ov32, z32, c32;
   logic [15:0] n32;

   int total  = 0;
   int bad    = 0;
   int issued = 0;

   always #5 clk = ~clk;

   pipe_datapath #(.DATA_W(16)) dut16 (
      .clk(clk), .reset(reset), .Instruction(instr), .instr_valid(iv),
      .DataInit(d16), .InitSel(sel), .ALUOut(o16), .out_valid(ov16),
      .zero_flag(z16), .carry_flag(c16), .retired_cnt(n16)
   );

   pipe_datapath #(.DATA_W(32)) dut32 (
      .clk(clk), .reset(reset), .Instruction(instr), .instr_valid(iv),
      .DataInit(d32), .InitSel(sel), .ALUOut(o32), .out_valid(ov32),
      .zero_flag(z32), .carry_flag(c32), .retired_cnt(n32)
   );

   task automatic step(input logic v, input logic s, input logic [15:0] ins,
                       input logic [15:0] a, input logic [31:0] b);
      @(negedge clk);
      iv = v; sel = s; instr = ins; d16 = a; d32 = b;
      if (v) issued++;
   endtask

   task automatic ld(input logic [3:0] rd, input logic [15:0] a, input logic [31:0] b);
      step(1'b1, 1'b1, {4'h0, rd, 8'h00}, a, b);
   endtask

   task automatic op(input logic [3:0] o, input logic [3:0] rd, input logic [3:0] r1, input logic [3:0] r2);
      step(1'b1, 1'b0, {o, rd, r1, r2}, 16'h0, 32'h0);
   endtask

   task automatic bub();
      step(1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1; iv = 1'b0; sel = 1'b0; instr = '0; d16 = '0; d32 = '0;
      #12;
      total++; if (o16 !== 16'h0) begin bad++; $display("FAIL rst_aluout got=%h exp=%h", o16, 16'h0); end
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ov16); end
      total++; if (z16 !== 1'b0 || c16 !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", z16, c16); end
      total++; if (n16 !== 16'h0 || n32 !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h/%h exp=0", n16, n32); end
      total++; if (o32 !== 32'h0) begin bad++; $display("FAIL rst_aluout32 got=%h exp=0", o32); end
      @(negedge clk);
      reset = 1'b0;
      issued = 0;
   endtask

   task automatic test_add();
      ld(4'd1, 16'h0005, 32'h5);
      ld(4'd2, 16'h0003, 32'h3);
      op(OP_ADD, 4'd3, 4'd1, 4'd2);
      bub(); bub();
      total++; if (o16 !== 16'h0008) begin bad++; $display("FAIL add_res got=%h exp=%h", o16, 16'h0008); end
      total++; if (c16 !== 1'b0 || z16 !== 1'b0) begin bad++; $display("FAIL add_flags got=c%b z%b exp=c0 z0", c16, z16); end
      total++; if (o32 !== 32'h8) begin bad++; $display("FAIL add_res32 got=%h exp=%h", o32, 32'h8); end
      total++; if (n16 !== 16'(issued)) begin bad++; $display("FAIL add_cnt got=%0d exp=%0d", n16, issued); end
   endtask

   task automatic test_addi();
      ld(4'd1, 16'hFFFF, 32'h0000FFFF);
      op(OP_ADDI, 4'd2, 4'd1, 4'd1);
      bub();
      total++; if (o16 !== 16'hFFFF || ov16 !== 1'b1) begin bad++; $display("FAIL addi_load got=%h v%b exp=ffff v1", o16, ov16); end
      bub();
      total++; if (o16 !== 16'h0000) begin bad++; $display("FAIL addi_res got=%h exp=0000", o16); end
      total++; if (z16 !== 1'b1 || c16 !== 1'b1) begin bad++; $display("FAIL addi_flags got=z%b c%b exp=z1 c1", z16, c16); end
      total++; if (o32 !== 32'h00010000 || c32 !== 1'b0 || z32 !== 1'b0) begin
         bad++; $display("FAIL addi_32 got=%h c%b z%b exp=00010000 c0 z0", o32, c32, z32); end
   endtask

   task automatic test_sub();
      ld(4'd1, 16'h0003, 32'h3);
      ld(4'd2, 16'h0005, 32'h5);
      op(OP_SUB, 4'd3, 4'd1, 4'd2);
      op(OP_SUB, 4'd4, 4'd2, 4'd1);
      bub();
      total++; if (o16 !== 16'hFFFE || c16 !== 1'b0) begin bad++; $display("FAIL sub_borrow got=%h c%b exp=fffe c0", o16, c16); end
      total++; if (o32 !== 32'hFFFFFFFE) begin bad++; $display("FAIL sub_borrow32 got=%h exp=fffffffe", o32); end
      bub();
      total++; if (o16 !== 16'h0002 || c16 !== 1'b1) begin bad++; $display("FAIL sub_noborrow got=%h c%b exp=0002 c1", o16, c16); end
      bub();
      total++; if (ov16 !== 1'b0 || o16 !== 16'h0002 || c16 !== 1'b1) begin
         bad++; $display("FAIL idle_hold got=%h v%b c%b exp=0002 v0 c1", o16, ov16, c16); end
      total++; if (n16 !== 16'(issued)) begin bad++; $display("FAIL sub_cnt got=%0d exp=%0d", n16, issued); end
   endtask

   task automatic test_logic();
      ld(4'd1, 16'h0F0F, 32'h0F0F);
      ld(4'd2, 16'h00FF, 32'h00FF);
      op(OP_AND, 4'd3, 4'd1, 4'd2);
      op(OP_OR,  4'd4, 4'd1, 4'd2);
      op(OP_XOR, 4'd5, 4'd1, 4'd2);
      total++; if (o16 !== 16'h000F || c16 !== 1'b0) begin bad++; $display("FAIL and_res got=%h c%b exp=000f c0", o16, c16); end
      op(OP_NOT, 4'd6, 4'd1, 4'd0);
      total++; if (o16 !== 16'h0FFF) begin bad++; $display("FAIL or_res got=%h exp=0fff", o16); end
      op(OP_SRL, 4'd7, 4'd1, 4'd8);
      total++; if (o16 !== 16'h0FF0) begin bad++; $display("FAIL xor_res got=%h exp=0ff0", o16); end
      bub();
      total++; if (o16 !== 16'hF0F0 || o32 !== 32'hFFFFF0F0) begin bad++; $display("FAIL not_res got=%h/%h exp=f0f0/fffff0f0", o16, o32); end
      bub();
      total++; if (o16 !== 16'h000F) begin bad++; $display("FAIL srl_res got=%h exp=000f", o16); end
   endtask

   task automatic test_r0_nop();
      ld(4'd0, 16'h1234, 32'h1234);
      op(OP_MOV, 4'd4, 4'd0, 4'd0);
      ld(4'd5, 16'h00AA, 32'hAA);
      total++; if (o16 !== 16'h1234 || z16 !== 1'b0) begin bad++; $display("FAIL r0_load got=%h z%b exp=1234 z0", o16, z16); end
      op(OP_NOP_C, 4'd5, 4'd5, 4'd5);
      total++; if (o16 !== 16'h0000 || z16 !== 1'b1) begin bad++; $display("FAIL r0_read got=%h z%b exp=0000 z1", o16, z16); end
      bub();
      total++; if (o16 !== 16'h00AA || z16 !== 1'b0) begin bad++; $display("FAIL ld_aa got=%h z%b exp=00aa z0", o16, z16); end
      bub();
      total++; if (ov16 !== 1'b1 || o16 !== 16'h00AA || z16 !== 1'b0) begin
         bad++; $display("FAIL nop_retire got=%h v%b z%b exp=00aa v1 z0", o16, ov16, z16); end
      total++; if (n16 !== 16'(issued)) begin bad++; $display("FAIL nop_cnt got=%0d exp=%0d", n16, issued); end
      bub();
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL nop_pulse got=%b exp=0", ov16); end
   endtask

   task automatic test_shift();
      ld(4'd5, 16'h8000, 32'h80000000);
      op(OP_SRA, 4'd6, 4'd5, 4'd4);
      ld(4'd7, 16'h8001, 32'h80000001);
      op(OP_ROL, 4'd8, 4'd7, 4'd1);
      total++; if (o16 !== 16'hF800) begin bad++; $display("FAIL sra16 got=%h exp=f800", o16); end
      total++; if (o32 !== 32'hF8000000) begin bad++; $display("FAIL sra32 got=%h exp=f8000000", o32); end
      bub(); bub();
      total++; if (o16 !== 16'h0003) begin bad++; $display("FAIL rol16 got=%h exp=0003", o16); end
      total++; if (o32 !== 32'h00000003) begin bad++; $display("FAIL rol32 got=%h exp=00000003", o32); end
   endtask

   task automatic test_reset_midstream();
      ld(4'd1, 16'hAAAA, 32'hAAAA);
      op(OP_ADD, 4'd2, 4'd1, 4'd1);
      #2 reset = 1'b1;
      #1;
      total++; if (o16 !== 16'h0 || o32 !== 32'h0) begin bad++; $display("FAIL mid_aluout got=%h/%h exp=0", o16, o32); end
      total++; if (ov16 !== 1'b0 || z16 !== 1'b0 || c16 !== 1'b0) begin bad++; $display("FAIL mid_flags got=v%b z%b c%b exp=0", ov16, z16, c16); end
      total++; if (n16 !== 16'h0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", n16); end
      iv = 1'b0;
      @(negedge clk);
      total++; if (ov16 !== 1'b0 || n16 !== 16'h0) begin bad++; $display("FAIL mid_noretire got=v%b n%0d exp=v0 n0", ov16, n16); end
      reset = 1'b0;
      issued = 1;
      iv = 1'b1; sel = 1'b0; instr = {OP_MOV, 4'd9, 4'd1, 4'd0};
      bub(); bub();
      total++; if (ov16 !== 1'b1 || n16 !== 16'd1) begin bad++; $display("FAIL first_after_rst got=v%b n%0d exp=v1 n1", ov16, n16); end
      total++; if (o16 !== 16'h0 || z16 !== 1'b1) begin bad++; $display("FAIL regs_cleared got=%h z%b exp=0000 z1", o16, z16); end
   endtask

   task automatic test_wrap();
      repeat (65534) op(OP_NOP_F, 4'd0, 4'd0, 4'd0);
      bub(); bub();
      total++; if (n16 !== 16'hFFFF) begin bad++; $display("FAIL cnt_max got=%h exp=ffff", n16); end
      op(OP_NOP_F, 4'd0, 4'd0, 4'd0);
      bub(); bub();
      total++; if (n16 !== 16'h0000 || n32 !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h/%h exp=0000", n16, n32); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_addi();
      test_sub();
      test_logic();
      test_r0_nop();
      test_shift();
      test_reset_midstream();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter DATA_W, default 16; datapath and register width, legal range 16..64.
REQ-002 Parameter REG_CNT, default 16; register count, fixed at 16 by the 4-bit instruction fields.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Instruction  input  16  instruction word: opcode[15:12], rd[11:8], rs1[7:4], rs2/imm4[3:0].
REQ-006 instr_valid  input  1  Instruction/DataInit/InitSel sampled this edge when high.
REQ-007 DataInit  input  DATA_W  load value written to rd when InitSel high.
REQ-008 InitSel  input  1  1 = load DataInit into rd, opcode ignored; 0 = ALU op.
REQ-009 ALUOut  output  DATA_W  registered result of most recent retired instruction.
REQ-010 out_valid  output  1  high for exactly one cycle per retired instruction.
REQ-011 zero_flag, carry_flag  output  1 each  registered flags of most recent retired ALU op.
REQ-012 retired_cnt  output  16  count of retired instructions, wraps 0xFFFF -> 0x0000.

Function
REQ-013 Two stages: S1 captures decoded fields and operands at edge N; S2 computes, writes rd and updates outputs at edge N+1.
REQ-014 Accept one instruction per cycle, no stall; instr_valid low inserts a bubble.
REQ-015 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT rs1, 6 SLL, 7 SRL, 8 SRA, 9 ROL, A MOV rs1, B ADDI; C-F NOP.
REQ-016 Shift and rotate amount for opcodes 6-9 is imm4 (0..15); ADDI zero-extends imm4 to DATA_W.
REQ-017 Arithmetic is modulo 2^DATA_W.
REQ-018 carry_flag: ADD/ADDI = carry-out; SUB = 1 when rs1 >= rs2 unsigned (no borrow); cleared for all other ops.
REQ-019 zero_flag = (result == 0) for every ALU op and for loads.
REQ-020 Register R0 reads as 0; writes to R0 are discarded, but ALUOut, flags and out_valid still update.
REQ-021 NOP retires: out_valid = 1, retired_cnt increments, no register write; ALUOut and flags hold.
REQ-022 InitSel = 1: rd <= DataInit and ALUOut = DataInit at N+1; carry_flag cleared.
REQ-023 Bypass: an S1 operand whose source matches the rd of the S2 instruction writing at the same edge takes the S2 result, not the stale register; R0 is never bypassed.
REQ-024 Cycles with no retirement: out_valid = 0; ALUOut, flags and retired_cnt hold.

Reset
REQ-025 reset high clears all registers R0-R15, both pipeline stage valids, ALUOut, zero_flag, carry_flag, out_valid and retired_cnt to 0, immediately and asynchronously.
REQ-026 An instruction in flight when reset asserts is discarded and does not retire.
REQ-027 The first instruction is accepted on the first rising edge after reset deasserts.

Structure
REQ-028 Shared package dp_pkg holds the opcode enumeration, instruction field bit positions and the DATA_W default.
REQ-029 Combinational sub-module alu_core (operands, opcode, imm4 -> result, carry) is instantiated once; the register file and pipeline are inline.

Verification
REQ-030 Load R1 = 0x0005, then R2 = 0x0003, then ADD R3,R1,R2 back-to-back -> ALUOut 0x0008 two edges after the ADD is accepted, carry_flag 0.
REQ-031 Load R1 = 0xFFFF, then ADDI R2,R1,1 -> ALUOut 0x0000, zero_flag 1, carry_flag 1 (bypass exercised).
REQ-032 SUB R3,R1,R2 with R1 = 3, R2 = 5 -> ALUOut 0xFFFE, carry_flag 0; with R1 = 5, R2 = 3 -> 0x0002, carry_flag 1.
REQ-033 Load R0 = 0x1234, then MOV R4,R0 -> first ALUOut 0x1234, then ALUOut 0x0000 (R0 hardwired).
REQ-034 SRA imm4 = 4 on 0x8000 -> 0xF800; ROL imm4 = 1 on 0x8001 -> 0x0003; repeat both with DATA_W = 32.
REQ-035 Assert reset mid-stream with 2 instructions in flight -> all outputs 0 at once, no out_valid pulse, retired_cnt 0; 65536 retirements -> retired_cnt wraps to 0.
